dct_8_stage_3: RTL and testbench

- Third butterfly/rotation stage of the 8-point integer DCT in the visc_DCT accelerator unit.
- Sits directly downstream of dct_8_stage_2 and consumes its 8-lane, 512-bit vector.
- Applies the even-part sum/difference, the pi/8 rotation and the 1/sqrt2 scaling.
- Registered 2-stage pipeline with full valid/ready backpressure, replacing the always-ready combinational style of earlier stages.

---
 rtl/dct_8_pkg.sv | 34 +++
 rtl/dct_8_const_mul.sv | 29 ++
 rtl/dct_8_stage_3.sv | 84 ++++++++
 tb/tb_dct_8_stage_3.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dct_8_pkg.sv
// Shared widths, coefficients and lane types for the 8-point DCT stages.
package dct_8_pkg;

   localparam int unsigned LANE_W = 64;
   localparam int unsigned LANES  = 8;
   localparam int unsigned DATA_W = LANE_W * LANES;
   localparam int unsigned FRAC   = 14;
   localparam int unsigned COEF_W = 16;
   localparam int unsigned SUM_W  = LANE_W + 1;
   localparam int unsigned PROD_W = LANE_W + COEF_W;

   localparam logic signed [COEF_W-1:0] DCT8_C_PI8     = COEF_W'(15137);
   localparam logic signed [COEF_W-1:0] DCT8_S_PI8     = COEF_W'(6270);
   localparam logic signed [COEF_W-1:0] DCT8_INV_SQRT2 = COEF_W'(11585);

   // Three-multiply rotation: C*x3 + S*x2 = S*(x2+x3) + (C-S)*x3, S*x3 - C*x2 = S*(x2+x3) - (C+S)*x2
   localparam logic signed [COEF_W-1:0] DCT8_ROT_SUM  = DCT8_C_PI8 + DCT8_S_PI8;
   localparam logic signed [COEF_W-1:0] DCT8_ROT_DIFF = DCT8_C_PI8 - DCT8_S_PI8;

   localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (FRAC - 1);

   typedef logic [LANE_W-1:0]        lane_t;
   typedef lane_t [LANES-1:0]        vec_t;
   typedef logic signed [SUM_W-1:0]  sum_t;
   typedef logic signed [PROD_W-1:0] prod_t;

   // Round half up, floor shift, keep the low lane bits.
   function automatic lane_t round_shift(input prod_t x);
      prod_t r;
      r = (x + RND_HALF) >>> FRAC;
      return r[LANE_W-1:0];
   endfunction

endpackage

// File: rtl/dct_8_const_mul.sv
// Registered signed constant multiply with a full-width product.
module dct_8_const_mul
   import dct_8_pkg::*;
#(
   parameter int unsigned               A_W  = LANE_W,
   parameter logic signed [COEF_W-1:0]  COEF = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic signed [A_W-1:0]          a,
   output logic signed [A_W+COEF_W-1:0]   p
);

   localparam int unsigned P_W = A_W + COEF_W;

   logic signed [P_W-1:0] prod_c;

   assign prod_c = P_W'(a) * P_W'(COEF);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p <= '0;
      end else if (en) begin
         p <= prod_c;
      end
   end

endmodule

// File: rtl/dct_8_stage_3.sv
// DCT-8 stage 3: even sum/difference, pi/8 rotation and 1/sqrt2 scaling,
// as a two-register pipeline with valid/ready flow control.
module dct_8_stage_3
   import dct_8_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_data_in,
   input  logic              i_valid,
   output logic              i_ready,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_valid,
   input  logic              o_ready
);

   vec_t  a;
   logic  v1, v2, adv2, p1_load;
   lane_t a0_q, a1_q, a4_q, a7_q;
   sum_t  a23_sum;
   logic signed [SUM_W+COEF_W-1:0] p_sum;
   prod_t p_c3, p_s2, p_r5, p_r6;
   vec_t  y_d, y_q;

   assign a = i_data_in;

   // Stage 2 advances when it is empty or being drained this cycle.
   assign adv2    = v1 & (~v2 | o_ready);
   assign i_ready = ~v1 | adv2;
   assign p1_load = i_valid & i_ready;

   // Widened so the shared rotation term stays exact for extreme inputs.
   assign a23_sum = sum_t'($signed(a[2])) + sum_t'($signed(a[3]));

   dct_8_const_mul #(.A_W(SUM_W),  .COEF(DCT8_S_PI8)) u_mul_sum (
      .clk(clk), .rst(rst), .en(p1_load), .a(a23_sum), .p(p_sum));
   dct_8_const_mul #(.A_W(LANE_W), .COEF(DCT8_ROT_DIFF)) u_mul_c3 (
      .clk(clk), .rst(rst), .en(p1_load), .a(a[3]), .p(p_c3));
   dct_8_const_mul #(.A_W(LANE_W), .COEF(DCT8_ROT_SUM)) u_mul_s2 (
      .clk(clk), .rst(rst), .en(p1_load), .a(a[2]), .p(p_s2));
   dct_8_const_mul #(.A_W(LANE_W), .COEF(DCT8_INV_SQRT2)) u_mul_r5 (
      .clk(clk), .rst(rst), .en(p1_load), .a(a[5]), .p(p_r5));
   dct_8_const_mul #(.A_W(LANE_W), .COEF(DCT8_INV_SQRT2)) u_mul_r6 (
      .clk(clk), .rst(rst), .en(p1_load), .a(a[6]), .p(p_r6));

   always_comb begin
      y_d    = '0;
      y_d[0] = a0_q + a1_q;
      y_d[1] = a0_q - a1_q;
      y_d[2] = round_shift(prod_t'(p_sum) + p_c3);
      y_d[3] = round_shift(prod_t'(p_sum) - p_s2);
      y_d[4] = a4_q;
      y_d[5] = round_shift(p_r5);
      y_d[6] = round_shift(p_r6);
      y_d[7] = a7_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         a0_q <= '0;
         a1_q <= '0;
         a4_q <= '0;
         a7_q <= '0;
         y_q  <= '0;
      end else begin
         v1 <= p1_load | (v1 & ~adv2);
         v2 <= adv2 | (v2 & ~o_ready);
         if (p1_load) begin
            a0_q <= a[0];
            a1_q <= a[1];
            a4_q <= a[4];
            a7_q <= a[7];
         end
         if (adv2) begin
            y_q <= y_d;
         end
      end
   end

   assign o_data_out = y_q;
   assign o_valid    = v2;

endmodule

// File: tb/tb_dct_8_stage_3.sv
// Directed bench for dct_8_stage_3: reset, latency, streaming, backpressure, wrap.
module tb_dct_8_stage_3;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] i_data_in;
   logic         i_valid;
   logic         i_ready;
   logic [511:0] o_data_out;
   logic         o_valid;
   logic         o_ready;

   int n_tests = 0;
   int n_fail  = 0;

   logic [511:0] vin  [4];
   logic [511:0] vexp [4];

   localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

   always #5 clk = ~clk;

   dct_8_stage_3 dut (
      .clk(clk), .rst(rst),
      .i_data_in(i_data_in), .i_valid(i_valid), .i_ready(i_ready),
      .o_data_out(o_data_out), .o_valid(o_valid), .o_ready(o_ready));

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] mk(input logic [63:0] v0, input logic [63:0] v1,
                                       input logic [63:0] v2, input logic [63:0] v3,
                                       input logic [63:0] v4, input logic [63:0] v5,
                                       input logic [63:0] v6, input logic [63:0] v7);
      return {v7, v6, v5, v4, v3, v2, v1, v0};
   endfunction

   initial begin
      vin[0]  = mk(64'sd1, 64'sd2, 64'sd3, 64'sd4, 64'sd5, 64'sd6, 64'sd7, 64'sd8);
      vexp[0] = mk(64'sd3, -64'sd1, 64'sd5, -64'sd1, 64'sd5, 64'sd4, 64'sd5, 64'sd8);
      vin[1]  = mk(MAXP, MAXP, 64'sd0, 64'sd0, 64'sd0, -64'sd1, 64'sd0, 64'sd0);
      vexp[1] = mk(64'hFFFF_FFFF_FFFF_FFFE, 64'sd0, 64'sd0, 64'sd0, 64'sd0, -64'sd1,
                   64'sd0, 64'sd0);
      vin[2]  = mk(-64'sd5, 64'sd7, -64'sd16384, 64'sd16384, -64'sd100, 64'sd16384,
                   -64'sd16384, MINN);
      vexp[2] = mk(64'sd2, -64'sd12, 64'sd8867, 64'sd21407, -64'sd100, 64'sd11585,
                   -64'sd11585, MINN);
      vin[3]  = mk(MINN, 64'sd1, MAXP, MAXP, 64'h1234, MAXP, 64'sd0, -64'sd2);
      vexp[3] = mk(64'h8000_0000_0000_0001, MAXP, 64'hA73D_FFFF_FFFF_FFFF,
                   64'hBABA_0000_0000_0001, 64'h1234, 64'h5A81_FFFF_FFFF_FFFF,
                   64'sd0, -64'sd2);

      // Reset held low
      rst = 1'b0; i_valid = 1'b0; o_ready = 1'b1; i_data_in = '0;
      #12;
      check("rst_ovalid", 512'(o_valid), 512'(1'b0));
      check("rst_data",   o_data_out,    '0);
      check("rst_iready", 512'(i_ready), 512'(1'b1));
      @(negedge clk);
      rst = 1'b1;

      // Single vector, latency 2
      i_data_in = vin[0]; i_valid = 1'b1;
      tick;
      i_valid = 1'b0;
      check("single_lat1", 512'(o_valid), 512'(1'b0));
      tick;
      check("single_ovalid", 512'(o_valid), 512'(1'b1));
      check("single_data",   o_data_out,    vexp[0]);
      tick;
      check("single_done", 512'(o_valid), 512'(1'b0));

      // Back-to-back stream
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) begin
            i_data_in = vin[k-1];
            i_valid   = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         tick;
         check($sformatf("b2b_iready%0d", k), 512'(i_ready), 512'(1'b1));
         if (k >= 2 && k <= 5) begin
            check($sformatf("b2b_ovalid%0d", k), 512'(o_valid), 512'(1'b1));
            check($sformatf("b2b_data%0d", k),   o_data_out,    vexp[k-2]);
         end else if (k == 6) begin
            check("b2b_drained", 512'(o_valid), 512'(1'b0));
         end
      end

      // Backpressure: 5 stalled edges, third vector must wait
      o_ready = 1'b0; i_data_in = vin[0]; i_valid = 1'b1;
      tick;
      check("bp_rdy_a",   512'(i_ready), 512'(1'b1));
      check("bp_ov_a",    512'(o_valid), 512'(1'b0));
      i_data_in = vin[1];
      tick;
      check("bp_full",    512'(i_ready), 512'(1'b0));
      check("bp_ov_b",    512'(o_valid), 512'(1'b1));
      check("bp_data_b",  o_data_out,    vexp[0]);
      i_data_in = vin[2];
      for (int k = 0; k < 3; k++) begin
         tick;
         check($sformatf("bp_hold_rdy%0d", k),  512'(i_ready), 512'(1'b0));
         check($sformatf("bp_hold_ov%0d", k),   512'(o_valid), 512'(1'b1));
         check($sformatf("bp_hold_data%0d", k), o_data_out,    vexp[0]);
      end
      o_ready = 1'b1;
      #1;
      check("bp_release_rdy", 512'(i_ready), 512'(1'b1));
      tick;
      i_valid = 1'b0;
      check("bp_out_b_ov", 512'(o_valid), 512'(1'b1));
      check("bp_out_b",    o_data_out,    vexp[1]);
      tick;
      check("bp_out_c_ov", 512'(o_valid), 512'(1'b1));
      check("bp_out_c",    o_data_out,    vexp[2]);
      tick;
      check("bp_empty",    512'(o_valid), 512'(1'b0));

      // Reset while the pipeline is full
      o_ready = 1'b0; i_data_in = vin[2]; i_valid = 1'b1;
      tick;
      i_data_in = vin[3];
      tick;
      i_valid = 1'b0;
      check("mid_full_ov",  512'(o_valid), 512'(1'b1));
      check("mid_full_rdy", 512'(i_ready), 512'(1'b0));
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_ov",   512'(o_valid), 512'(1'b0));
      check("mid_rst_rdy",  512'(i_ready), 512'(1'b1));
      check("mid_rst_data", o_data_out,    '0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1; o_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         check($sformatf("mid_no_stale%0d", k), 512'(o_valid), 512'(1'b0));
      end
      i_data_in = vin[3]; i_valid = 1'b1;
      tick;
      i_valid = 1'b0;
      check("mid_new_lat1", 512'(o_valid), 512'(1'b0));
      tick;
      check("mid_new_ov",   512'(o_valid), 512'(1'b1));
      check("mid_new_data", o_data_out,    vexp[3]);
      tick;
      check("mid_new_done", 512'(o_valid), 512'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
